// File: rtl/kl10_scd_pkg.sv
// Shared definitions for the KL10-style shift/normalize step controller.
// Holds the FSM encoding, the shift-count width and the operand-length limits.
package kl10_scd_pkg;

  localparam int SC_W  = 10;
  localparam int MAG_W = SC_W + 1;   // one extra bit so |-512| is representable

  localparam int LIMIT_SINGLE = 36;
  localparam int LIMIT_DOUBLE = 72;

  typedef logic [0:SC_W-1]  sc_t;
  typedef logic [0:MAG_W-1] mag_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  function automatic sc_t limit_for(input logic dbl);
    return dbl ? sc_t'(LIMIT_DOUBLE) : sc_t'(LIMIT_SINGLE);
  endfunction

endpackage

// File: rtl/sc_mag_clamp.sv
// Combinational count preparation: direction from the sign, magnitude of the
// signed count, and clamping to the operand length.
module sc_mag_clamp
  import kl10_scd_pkg::*;
(
  input  logic            count_sign_ok,
  input  sc_t             count,
  input  logic            dbl,
  output logic            left,
  output sc_t             sc_load,
  output logic            sat
);

  mag_t ext;
  mag_t mag;
  sc_t  limit;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    ext     = {count[0], count};
    mag     = count[0] ? mag_t'(-ext) : ext;
    limit   = limit_for(dbl);
    left    = ~count[0] & count_sign_ok;
    sat     = 1'b0;
    sc_load = sc_t'(mag);
    if (mag > {1'b0, limit}) begin
      sat     = 1'b1;
      sc_load = limit;
    end
  end

endmodule

// File: rtl/scd_shift_ctl.sv
// Shift-count step controller: loads a clamped shift magnitude, then emits one
// STEP per cycle until the count is exhausted, finishing with a DONE pulse.
module scd_shift_ctl
  import kl10_scd_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic        START,
  input  logic [0:9]  COUNT,
  input  logic        DOUBLE,
  input  logic        ABORT,
  output logic        BUSY,
  output logic        STEP,
  output logic        LEFT,
  output logic [0:9]  SC,
  output logic        SAT,
  output logic        DONE
);

  state_t state_q;
  state_t state_d;

  sc_t    count_q;
  logic   dbl_q;

  logic   left_load;
  sc_t    sc_load;
  logic   sat_load;

  sc_mag_clamp u_clamp (
    .count_sign_ok (1'b1),
    .count         (count_q),
    .dbl           (dbl_q),
    .left          (left_load),
    .sc_load       (sc_load),
    .sat           (sat_load)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (START) state_d = S_LOAD;
        S_LOAD:  state_d = (sc_load == '0) ? S_FIN : S_SHIFT;
        S_SHIFT: if (SC == sc_t'(1)) state_d = S_FIN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY = (state_q != S_IDLE);
    STEP = (state_q == S_SHIFT);
    DONE = (state_q == S_FIN);
  end

  // Captured operand and the step counter; LEFT/SAT only change at LOAD.
  always_ff @(posedge clk) begin
    if (RESET) begin
      count_q <= '0;
      dbl_q   <= 1'b0;
      SC      <= '0;
      LEFT    <= 1'b0;
      SAT     <= 1'b0;
    end else if (ABORT) begin
      SC      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            count_q <= COUNT;
            dbl_q   <= DOUBLE;
          end
        end
        S_LOAD: begin
          SC   <= sc_load;
          LEFT <= left_load;
          SAT  <= sat_load;
        end
        S_SHIFT: begin
          if (SC != '0) SC <= SC - sc_t'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scd_shift_ctl.sv
// Directed bench for scd_shift_ctl: hand-computed step counts, clamping,
// abort/reset behaviour and START filtering while busy.
module tb_scd_shift_ctl;

  logic       clk = 1'b0;
  logic       RESET, START, DOUBLE, ABORT;
  logic [0:9] COUNT;
  logic       BUSY, STEP, LEFT, SAT, DONE;
  logic [0:9] SC;

  int vectors     = 0;
  int miscompares = 0;

  scd_shift_ctl dut (
    .clk    (clk),
    .RESET  (RESET),
    .START  (START),
    .COUNT  (COUNT),
    .DOUBLE (DOUBLE),
    .ABORT  (ABORT),
    .BUSY   (BUSY),
    .STEP   (STEP),
    .LEFT   (LEFT),
    .SC     (SC),
    .SAT    (SAT),
    .DONE   (DONE)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [0:9] cnt, input logic dbl);
    COUNT  = cnt;
    DOUBLE = dbl;
    START  = 1'b1;
    tick();
    START  = 1'b0;
    chk("load_busy", 32'(BUSY), 1);
    chk("load_step", 32'(STEP), 0);
    chk("load_done", 32'(DONE), 0);
  endtask

  // Full sequence: n STEP cycles with SC counting n..1, then FIN, then IDLE.
  task automatic run_seq(input string tag, input logic [0:9] cnt, input logic dbl,
                         input int n, input logic exp_left, input logic exp_sat);
    start_seq(cnt, dbl);
    tick();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_step"}, 32'(STEP), 1);
      chk({tag, "_sc"},   32'(SC), 32'(n - i));
      chk({tag, "_done"}, 32'(DONE), 0);
      if (i == 0) begin
        chk({tag, "_left"}, 32'(LEFT), 32'(exp_left));
        chk({tag, "_sat"},  32'(SAT),  32'(exp_sat));
      end
      tick();
    end
    chk({tag, "_fin_done"}, 32'(DONE), 1);
    chk({tag, "_fin_step"}, 32'(STEP), 0);
    chk({tag, "_fin_sc"},   32'(SC), 0);
    chk({tag, "_fin_busy"}, 32'(BUSY), 1);
    chk({tag, "_fin_left"}, 32'(LEFT), 32'(exp_left));
    chk({tag, "_fin_sat"},  32'(SAT),  32'(exp_sat));
    tick();
    chk({tag, "_idle_busy"}, 32'(BUSY), 0);
    chk({tag, "_idle_done"}, 32'(DONE), 0);
    chk({tag, "_idle_sc"},   32'(SC), 0);
  endtask

  initial begin
    int dones;
    int steps;

    RESET  = 1'b1;
    START  = 1'b1;
    ABORT  = 1'b1;
    COUNT  = 10'd5;
    DOUBLE = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_step", 32'(STEP), 0);
    chk("rst_left", 32'(LEFT), 0);
    chk("rst_sc",   32'(SC),   0);
    chk("rst_sat",  32'(SAT),  0);
    chk("rst_done", 32'(DONE), 0);
    RESET = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    tick();

    // Basic left/right shifts, clamp boundaries and the zero count.
    run_seq("p5",      10'd5,     1'b0, 5,  1'b1, 1'b0);
    run_seq("m3",      10'h3FD,   1'b0, 3,  1'b0, 1'b0);
    run_seq("p100s",   10'd100,   1'b0, 36, 1'b1, 1'b1);
    run_seq("p100d",   10'd100,   1'b1, 72, 1'b1, 1'b1);
    run_seq("m512d",   10'h200,   1'b1, 72, 1'b0, 1'b1);
    run_seq("p36s",    10'd36,    1'b0, 36, 1'b1, 1'b0);
    run_seq("m37s",    10'h3DB,   1'b0, 36, 1'b0, 1'b1);
    run_seq("zero",    10'd0,     1'b0, 0,  1'b1, 1'b0);

    // Abort during the third STEP of a count of 10.
    start_seq(10'd10, 1'b0);
    tick();
    tick();
    tick();
    chk("ab_sc3", 32'(SC), 8);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_busy", 32'(BUSY), 0);
    chk("ab_sc",   32'(SC),   0);
    chk("ab_step", 32'(STEP), 0);
    chk("ab_left", 32'(LEFT), 1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (DONE) dones++;
      tick();
    end
    chk("ab_no_done", 32'(dones), 0);

    // START together with ABORT in IDLE must not start anything.
    COUNT = 10'd4;
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("sa_busy", 32'(BUSY), 0);
    tick();
    chk("sa_busy2", 32'(BUSY), 0);
    chk("sa_sc",    32'(SC),   0);

    // START during SHIFT is ignored: exactly 4 STEPs and one DONE.
    start_seq(10'd4, 1'b0);
    tick();
    START = 1'b1;
    dones = 0;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) START = 1'b0;
      if (DONE) dones++;
      if (STEP) steps++;
      if (STEP && DONE) chk("sd_overlap", 1, 0);
      tick();
    end
    chk("sd_dones", 32'(dones), 1);
    chk("sd_steps", 32'(steps), 4);
    chk("sd_idle",  32'(BUSY),  0);

    // START presented in FIN is not accepted.
    start_seq(10'd0, 1'b0);
    tick();
    chk("fs_done", 32'(DONE), 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("fs_busy", 32'(BUSY), 0);
    tick();
    chk("fs_busy2", 32'(BUSY), 0);

    // RESET in the middle of SHIFT clears every output at that edge.
    start_seq(10'd100, 1'b0);
    tick();
    tick();
    chk("rm_step", 32'(STEP), 1);
    chk("rm_sat",  32'(SAT),  1);
    RESET = 1'b1;
    START = 1'b1;
    tick();
    chk("rm_busy", 32'(BUSY), 0);
    chk("rm_step0", 32'(STEP), 0);
    chk("rm_left", 32'(LEFT), 0);
    chk("rm_sc",   32'(SC),   0);
    chk("rm_sat0", 32'(SAT),  0);
    chk("rm_done", 32'(DONE), 0);
    RESET = 1'b0;
    START = 1'b0;
    tick();
    run_seq("post", 10'd2, 1'b1, 2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scd_shift_ctl.md
SCD_SHIFT_CTL -- requirements
Module: scd_shift_ctl

Interface
REQ-001 SHALL have ports, clock and reset first, listed as name, direction, width and meaning:
- clk  in  1  single system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request to begin a shift/normalize step sequence.
- COUNT  in  [0:9]  signed two's-complement shift count (SC width); negative means a right shift.
- DOUBLE  in  1  selects a 72-bit operand; otherwise the operand is 36 bits.
- ABORT  in  1  cancel the sequence (page fail or interrupt).
- BUSY  out  1  sequence in progress.
- STEP  out  1  one-bit shift enable for the AR/ARX datapath this cycle.
- LEFT  out  1  shift direction; 1 means left.
- SC  out  [0:9]  remaining step count.
- SAT  out  1  the count was clamped.
- DONE  out  1  single-cycle completion pulse.
REQ-002 SHALL use one clock, clk; reset RESET is synchronous and active-high.

Function
REQ-003 SHALL implement the states IDLE, LOAD, SHIFT and FIN.
REQ-004 IDLE: START=1 and ABORT=0 SHALL capture COUNT and DOUBLE and go to LOAD on the next edge.
REQ-005 LOAD (one cycle) SHALL perform all of the following:
- LEFT <= ~COUNT[0].
- Compute the magnitude |COUNT| in 11 bits, so that -512 yields 512.
- Set limit = 72 if DOUBLE else 36.
- If the magnitude exceeds limit, set SC <= limit and SAT <= 1; otherwise set SC <= magnitude and SAT <= 0.
REQ-006 LOAD with a resulting SC = 0 SHALL go to FIN and emit no STEP.
REQ-007 LOAD with SC > 0 SHALL go to SHIFT.
REQ-008 SHIFT SHALL assert STEP every cycle and decrement SC by 1 per cycle.
REQ-009 SHIFT SHALL go to FIN on the cycle STEP is asserted with SC = 1, so exactly N STEP cycles occur for a loaded count N.
REQ-010 FIN SHALL assert DONE for exactly one cycle and then return to IDLE.
REQ-011 BUSY SHALL be 1 in LOAD, SHIFT and FIN, and 0 in IDLE.
REQ-012 Latency: with START sampled at edge t, the first STEP is visible in cycle t+2. DONE is visible in cycle t+2+N, where N is the loaded SC.
REQ-013 START while BUSY=1 SHALL be ignored; it is neither queued nor allowed to restart the sequence.
REQ-014 ABORT=1 in any state SHALL return the block to IDLE on the next edge, with SC <= 0 and no DONE pulse.
REQ-015 ABORT SHALL dominate START when both are asserted in IDLE in the same cycle.
REQ-016 FIN with START=1 SHALL NOT start a new sequence; a new START is accepted only from IDLE.
REQ-017 STEP and DONE SHALL never be asserted in the same cycle.
REQ-018 SC SHALL never underflow, never exceed 72, and SHALL hold its value in IDLE.
REQ-019 SAT and LEFT SHALL hold from LOAD until the next LOAD or until reset.

Reset
REQ-020 On RESET the state SHALL be IDLE and every output SHALL be 0: BUSY, STEP, LEFT, SC, SAT and DONE.
REQ-021 RESET SHALL override ABORT and START and SHALL take effect at the same edge, including in the middle of SHIFT.

Structure
REQ-022 The state encoding, SC width (10) and the limits 36 and 72 SHALL live in a shared package, kl10_scd_pkg.
REQ-023 SHALL use one natural sub-module, sc_mag_clamp: a combinational block computing magnitude, LEFT and the clamp. The FSM and counter SHALL be in the top module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- COUNT=+5, DOUBLE=0 -> LEFT=1, STEP for 5 consecutive cycles starting at t+2, DONE at t+7, SAT=0.
- COUNT=-3 -> LEFT=0, 3 STEP cycles, SC sequence 3,2,1,0.
- COUNT=+100, DOUBLE=0 -> SC=36, SAT=1, 36 STEPs. With DOUBLE=1 -> SC=72, 72 STEPs. COUNT=-512, DOUBLE=1 -> SC=72, SAT=1.
- COUNT=0 -> BUSY for 2 cycles, no STEP, DONE at t+2.
- ABORT during the 3rd STEP of COUNT=10 -> IDLE next cycle, SC=0, no DONE. START in IDLE together with ABORT -> no sequence starts.
- RESET mid-SHIFT -> all outputs 0 next cycle. START during SHIFT -> ignored, exactly one DONE.
